mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage of the 64-bit five-stage RISC-V pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of write-back. It consumes the EX/MEM payload (ALU result, store data, destination register and control bits) and does three things:
- resolves the branch decision;
- performs doubleword loads/stores over a req/ack data-memory handshake with misalignment and timeout checking;
- registers the result as the MEM/WB payload.

While a memory access is outstanding it stalls the upstream pipeline.

## Interface
Parameters:
- XLEN, 64, datapath and address width
- TIMEOUT, 255, maximum cycles to wait for dmem_ack before aborting (1..255, 8-bit counter)

Ports:
- clk  input  1  pipeline clock; single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EX/MEM slot holds a real instruction
- alu_data  input  XLEN  ALU result; effective address for loads/stores
- rs_2  input  XLEN  store data
- rd  input  5  destination register index
- mem_to_reg, regwrite, branch, mem_read, mem_write  input  1 each  control bits from EX/MEM
- zero  input  1  ALU zero flag
- pc_branch  input  32  branch target
- pc_src  output  1  take branch (combinational)
- pc_branch_out  output  32  branch target passthrough (combinational)
- stall  output  1  hold EX/MEM and all earlier stages (combinational)
- dmem_req, dmem_we  output  1 each  memory request / write enable (registered)
- dmem_addr, dmem_wdata  output  XLEN each  address / store data (registered)
- dmem_ack  input  1  memory completion, one-cycle pulse
- dmem_rdata  input  XLEN  load data, valid when dmem_ack=1
- wb_valid, wb_regwrite, wb_mem_to_reg  output  1 each  MEM/WB control (registered)
- wb_alu_data, wb_mem_data  output  XLEN each  MEM/WB data (registered)
- wb_rd  output  5  MEM/WB destination (registered)
- misalign_err, bus_err  output  1 each  one-cycle error pulses (registered)

## Operation
- access = in_valid & (mem_read | mem_write). aligned = (alu_data[2:0] == 0). If mem_read and mem_write are both set, treat the access as a write.
- pc_src = in_valid & branch & zero. It is unaffected by stall or by the FSM state.

FSM states: IDLE, ACCESS.

- **IDLE, access & aligned:**
  - Load dmem_addr = alu_data, dmem_wdata = rs_2, dmem_we = mem_write; set dmem_req = 1.
  - Latch rd, regwrite and mem_to_reg.
  - Clear the timeout counter and go to ACCESS.
  - stall = 1.
- **IDLE, access & misaligned:**
  - No request is issued; stall = 0.
  - Pulse misalign_err.
  - MEM/WB captures the slot with wb_valid = 1 and wb_regwrite = 0.
- **IDLE, no access:**
  - stall = 0.
  - MEM/WB captures alu_data, rd, regwrite, mem_to_reg; wb_valid = in_valid; wb_mem_data holds its value.
- **ACCESS:**
  - dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable.
  - stall = !dmem_ack & (count != TIMEOUT).
  - The counter increments each cycle dmem_ack = 0.
- **ACCESS, dmem_ack = 1:**
  - Drop dmem_req; wb_mem_data = dmem_rdata; wb_alu_data = the latched address.
  - wb_valid = 1 with the latched control bits; go to IDLE.
- **ACCESS, count == TIMEOUT and no ack:**
  - Drop dmem_req and pulse bus_err.
  - wb_valid = 1, wb_regwrite = 0; go to IDLE.
- **dmem_ack in IDLE:** ignored.
- **While stall = 1:** wb_valid = 0 (bubble into write-back).
- **Reset:**
  - All registered outputs go to 0 and the state goes to IDLE, including in the middle of an ACCESS.
  - The outstanding request is abandoned; a late dmem_ack is ignored.

## Timing
- Non-memory instruction: 1-cycle latency to MEM/WB.
- Memory access:
  - Presented at edge 0; the request is visible after edge 1.
  - An ack sampled at edge 1+k writes MEM/WB at that same edge.
  - stall is high for cycles 0..k and low in the ack cycle, so upstream advances at the ack edge.
- Timeout: the error is flagged at most TIMEOUT+1 cycles after dmem_req rises.
- Back-to-back accesses: minimum of 2 cycles per access (IDLE→ACCESS→IDLE); dmem_req drops for at least one cycle between requests.
- Error pulses last exactly one cycle, coincident with the corresponding wb_valid.

## Test plan
- Reset: hold rst for 2 cycles mid-ACCESS → every output reads 0 and state is IDLE; a dmem_ack asserted after reset produces no wb_valid.
- ALU op, in_valid=1, regwrite=1, rd=5, alu_data=0x2A, no mem → next cycle wb_valid=1, wb_rd=5, wb_alu_data=0x2A; stall never asserted.
- Load from 0x1000, memory acks 3 cycles after req with rdata=0xDEADBEEF → stall high for 4 cycles; wb_mem_data=0xDEADBEEF and wb_mem_to_reg=1 at the ack edge.
- Store to 0x18, rs_2=0x55, ack=1 on the first ACCESS cycle → dmem_we=1, dmem_wdata=0x55, one stall cycle; wb_regwrite=0.
- Load at 0x1004 → misalign_err pulses, dmem_req stays 0, wb_regwrite=0.
- No ack with TIMEOUT=4 → bus_err after 5 ACCESS cycles, then the stage returns to IDLE; also branch=1, zero=1 during the stall → pc_src=1, pc_branch_out equals pc_branch.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the 64-bit five-stage RISC-V pipeline. It resolves the branch
// decision, performs doubleword loads/stores over a req/ack data-memory
// handshake with alignment and timeout checking, and registers the MEM/WB
// payload. While a memory access is outstanding it stalls the upstream pipe.
module mem_access_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,

  // EX/MEM payload
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] rs_2,
  input  logic [4:0]      rd,
  input  logic            mem_to_reg,
  input  logic            regwrite,
  input  logic            branch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            zero,
  input  logic [31:0]     pc_branch,

  // Branch resolution and pipeline control
  output logic            pc_src,
  output logic [31:0]     pc_branch_out,
  output logic            stall,

  // Data-memory handshake
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,

  // MEM/WB payload
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic            wb_mem_to_reg,
  output logic [XLEN-1:0] wb_alu_data,
  output logic [XLEN-1:0] wb_mem_data,
  output logic [4:0]      wb_rd,

  // Error pulses, coincident with the wb_valid of the faulting slot
  output logic            misalign_err,
  output logic            bus_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // The wait counter is 8 bits wide, so the limit is taken modulo 256.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t          state_q, state_d;
  logic [7:0]      count_q, count_d;

  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;

  // Control bits of the instruction that owns the outstanding access
  logic [4:0]      lat_rd_q, lat_rd_d;
  logic            lat_regwrite_q, lat_regwrite_d;
  logic            lat_mem_to_reg_q, lat_mem_to_reg_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_regwrite_q, wb_regwrite_d;
  logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [XLEN-1:0] wb_alu_data_q, wb_alu_data_d;
  logic [XLEN-1:0] wb_mem_data_q, wb_mem_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;

  logic            misalign_err_q, misalign_err_d;
  logic            bus_err_q, bus_err_d;

  logic            stall_c;
  logic            access;
  logic            aligned;
  logic            timeout_hit;

  // A slot touches memory when it is real and either reads or writes;
  // when both bits are set, dmem_we follows mem_write so it becomes a write.
  assign access      = in_valid & (mem_read | mem_write);
  assign aligned     = (alu_data[2:0] == 3'b000);
  assign timeout_hit = (count_q == TIMEOUT_C);

  // Branch decision is purely combinational and independent of the FSM.
  assign pc_src        = in_valid & branch & zero;
  assign pc_branch_out = pc_branch;

  // Next-state, handshake and MEM/WB payload computation.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    lat_rd_d         = lat_rd_q;
    lat_regwrite_d   = lat_regwrite_q;
    lat_mem_to_reg_d = lat_mem_to_reg_q;
    wb_valid_d       = 1'b0;
    wb_regwrite_d    = wb_regwrite_q;
    wb_mem_to_reg_d  = wb_mem_to_reg_q;
    wb_alu_data_d    = wb_alu_data_q;
    wb_mem_data_d    = wb_mem_data_q;
    wb_rd_d          = wb_rd_q;
    misalign_err_d   = 1'b0;
    bus_err_d        = 1'b0;
    stall_c          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access && aligned) begin
          // Launch the request; the slot is held upstream until completion
          // and a bubble goes to write-back meanwhile.
          dmem_req_d       = 1'b1;
          dmem_we_d        = mem_write;
          dmem_addr_d      = alu_data;
          dmem_wdata_d     = rs_2;
          lat_rd_d         = rd;
          lat_regwrite_d   = regwrite;
          lat_mem_to_reg_d = mem_to_reg;
          count_d          = 8'd0;
          state_d          = ACCESS;
          stall_c          = 1'b1;
        end else if (access) begin
          // Misaligned: retire the slot without touching memory and
          // suppress its register write.
          misalign_err_d  = 1'b1;
          wb_valid_d      = 1'b1;
          wb_regwrite_d   = 1'b0;
          wb_mem_to_reg_d = mem_to_reg;
          wb_alu_data_d   = alu_data;
          wb_rd_d         = rd;
        end else begin
          // Non-memory slot (or empty slot) passes straight through.
          wb_valid_d      = in_valid;
          wb_regwrite_d   = regwrite;
          wb_mem_to_reg_d = mem_to_reg;
          wb_alu_data_d   = alu_data;
          wb_rd_d         = rd;
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          // Completion: retire with the latched control bits and address.
          dmem_req_d      = 1'b0;
          dmem_we_d       = 1'b0;
          wb_valid_d      = 1'b1;
          wb_regwrite_d   = lat_regwrite_q;
          wb_mem_to_reg_d = lat_mem_to_reg_q;
          wb_alu_data_d   = dmem_addr_q;
          wb_mem_data_d   = dmem_rdata;
          wb_rd_d         = lat_rd_q;
          state_d         = IDLE;
        end else if (timeout_hit) begin
          // Give up on the bus: retire the slot with its write suppressed.
          dmem_req_d      = 1'b0;
          dmem_we_d       = 1'b0;
          bus_err_d       = 1'b1;
          wb_valid_d      = 1'b1;
          wb_regwrite_d   = 1'b0;
          wb_mem_to_reg_d = lat_mem_to_reg_q;
          wb_alu_data_d   = dmem_addr_q;
          wb_rd_d         = lat_rd_q;
          state_d         = IDLE;
        end else begin
          // Still waiting: hold the request stable and keep upstream frozen.
          count_d = count_q + 8'd1;
          stall_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and all registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      count_q          <= 8'd0;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      lat_rd_q         <= 5'd0;
      lat_regwrite_q   <= 1'b0;
      lat_mem_to_reg_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_regwrite_q    <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_alu_data_q    <= '0;
      wb_mem_data_q    <= '0;
      wb_rd_q          <= 5'd0;
      misalign_err_q   <= 1'b0;
      bus_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      lat_rd_q         <= lat_rd_d;
      lat_regwrite_q   <= lat_regwrite_d;
      lat_mem_to_reg_q <= lat_mem_to_reg_d;
      wb_valid_q       <= wb_valid_d;
      wb_regwrite_q    <= wb_regwrite_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_alu_data_q    <= wb_alu_data_d;
      wb_mem_data_q    <= wb_mem_data_d;
      wb_rd_q          <= wb_rd_d;
      misalign_err_q   <= misalign_err_d;
      bus_err_q        <= bus_err_d;
    end
  end

  assign stall         = stall_c;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_alu_data   = wb_alu_data_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign wb_rd         = wb_rd_q;
  assign misalign_err  = misalign_err_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT = 4). Each cycle: inputs are
// driven 1 time unit after the rising edge, outputs are checked on the
// falling edge.
module tb_mem_access_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] alu_data;
  logic [XLEN-1:0] rs_2;
  logic [4:0]      rd;
  logic            mem_to_reg, regwrite, branch, mem_read, mem_write, zero;
  logic [31:0]     pc_branch;
  logic            pc_src;
  logic [31:0]     pc_branch_out;
  logic            stall;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_valid, wb_regwrite, wb_mem_to_reg;
  logic [XLEN-1:0] wb_alu_data, wb_mem_data;
  logic [4:0]      wb_rd;
  logic            misalign_err, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .alu_data(alu_data), .rs_2(rs_2), .rd(rd),
    .mem_to_reg(mem_to_reg), .regwrite(regwrite), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .zero(zero),
    .pc_branch(pc_branch), .pc_src(pc_src), .pc_branch_out(pc_branch_out),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_data(wb_alu_data),
    .wb_mem_data(wb_mem_data), .wb_rd(wb_rd),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; alu_data = '0; rs_2 = '0; rd = '0; mem_to_reg = 0;
    regwrite = 0; branch = 0; mem_read = 0; mem_write = 0; zero = 0;
    pc_branch = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    rst = 1; clear_in();
    tick(); tick();
    @(negedge clk);
    ctl = {dmem_req, dmem_we, wb_valid, wb_regwrite, wb_mem_to_reg, misalign_err, bus_err, stall, pc_src, 1'b0};
    checks++; if (ctl !== 10'd0) begin errors++; $display("FAIL reset_ctl: got %b want 0", ctl); end
    checks++; if ({dmem_addr, dmem_wdata, wb_alu_data, wb_mem_data} !== '0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_data: addr=%h wb_alu=%h wb_rd=%0d want 0", dmem_addr, wb_alu_data, wb_rd); end
    $display("reset: power-on state checked");
    // Start a load, then reset mid-ACCESS for two cycles.
    tick(); rst = 0;
    tick(); in_valid = 1; mem_read = 1; regwrite = 1; mem_to_reg = 1; rd = 5'd3; alu_data = 64'h1000; rs_2 = 64'h77;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL reset_pre_req: got %b want 1", dmem_req); end
    tick(); rst = 1; clear_in();
    tick();
    @(negedge clk);
    ctl = {dmem_req, dmem_we, wb_valid, wb_regwrite, wb_mem_to_reg, misalign_err, bus_err, stall, pc_src, 1'b0};
    checks++; if (ctl !== 10'd0) begin errors++; $display("FAIL reset_mid_ctl: got %b want 0", ctl); end
    checks++; if (dmem_addr !== '0 || dmem_wdata !== '0) begin errors++; $display("FAIL reset_mid_addr: addr=%h wdata=%h want 0", dmem_addr, dmem_wdata); end
    // Late ack after reset must be ignored.
    tick(); rst = 0; dmem_ack = 1; dmem_rdata = 64'hBAD;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_late_ack_stall: got %b want 0", stall); end
    tick(); dmem_ack = 0; dmem_rdata = '0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0 || wb_mem_data !== '0) begin errors++; $display("FAIL reset_late_ack: wb_valid=%b wb_mem_data=%h want 0/0", wb_valid, wb_mem_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_late_ack_req: got %b want 0", dmem_req); end
    $display("reset: mid-access reset and late ack checked");
  endtask

  task automatic test_alu_op();
    tick(); clear_in(); in_valid = 1; regwrite = 1; rd = 5'd5; alu_data = 64'h2A;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin errors++; $display("FAIL alu_wb_ctl: valid=%b rd=%0d rw=%b want 1/5/1", wb_valid, wb_rd, wb_regwrite); end
    checks++; if (wb_alu_data !== 64'h2A) begin errors++; $display("FAIL alu_wb_data: got %h want 2a", wb_alu_data); end
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_mem: stall=%b req=%b want 0/0", stall, dmem_req); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_empty_slot: got %b want 0", wb_valid); end
    $display("alu: rd=5 data=0x2a passthrough checked");
  endtask

  task automatic test_load();
    int stall_cnt;
    stall_cnt = 0;
    tick(); clear_in(); in_valid = 1; mem_read = 1; mem_to_reg = 1; regwrite = 1; rd = 5'd7; alu_data = 64'h1000;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_c0: got %b want 0", dmem_req); end
    if (stall === 1'b1) stall_cnt++;
    for (int c = 1; c <= 3; c++) begin
      tick();
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000 || dmem_we !== 1'b0) begin errors++; $display("FAIL load_req_c%0d: req=%b addr=%h we=%b want 1/1000/0", c, dmem_req, dmem_addr, dmem_we); end
      if (stall === 1'b1) stall_cnt++;
    end
    tick(); dmem_ack = 1; dmem_rdata = 64'hDEADBEEF;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall: got %b want 0", stall); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_bubble: got %b want 0", wb_valid); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_regwrite !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL load_wb_ctl: valid=%b m2r=%b rw=%b rd=%0d want 1/1/1/7", wb_valid, wb_mem_to_reg, wb_regwrite, wb_rd); end
    checks++; if (wb_mem_data !== 64'hDEADBEEF) begin errors++; $display("FAIL load_wb_data: got %h want deadbeef", wb_mem_data); end
    checks++; if (wb_alu_data !== 64'h1000) begin errors++; $display("FAIL load_wb_addr: got %h want 1000", wb_alu_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b want 0", dmem_req); end
    checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
    $display("load: addr=0x1000 rdata=0xdeadbeef stall_cycles=%0d", stall_cnt);
  endtask

  task automatic test_store();
    tick(); clear_in(); in_valid = 1; mem_write = 1; rs_2 = 64'h55; alu_data = 64'h18; rd = 5'd3;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_stall_c0: got %b want 1", stall); end
    tick(); dmem_ack = 1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL store_req: req=%b we=%b want 1/1", dmem_req, dmem_we); end
    checks++; if (dmem_wdata !== 64'h55 || dmem_addr !== 64'h18) begin errors++; $display("FAIL store_data: wdata=%h addr=%h want 55/18", dmem_wdata, dmem_addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_ack_stall: got %b want 0", stall); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL store_wb: valid=%b rw=%b req=%b want 1/0/0", wb_valid, wb_regwrite, dmem_req); end
    $display("store: addr=0x18 wdata=0x55 checked");
  endtask

  task automatic test_misalign();
    tick(); clear_in(); in_valid = 1; mem_read = 1; regwrite = 1; rd = 5'd9; alu_data = 64'h1004;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL misalign_c0: stall=%b req=%b want 0/0", stall, dmem_req); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse: mis=%b bus=%b want 1/0", misalign_err, bus_err); end
    checks++; if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || wb_rd !== 5'd9) begin errors++; $display("FAIL misalign_wb: valid=%b rw=%b rd=%0d want 1/0/9", wb_valid, wb_regwrite, wb_rd); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL misalign_req: got %b want 0", dmem_req); end
    tick();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL misalign_one_cycle: mis=%b valid=%b want 0/0", misalign_err, wb_valid); end
    $display("misalign: addr=0x1004 checked");
  endtask

  task automatic test_timeout_branch();
    logic exp_stall;
    tick(); clear_in(); in_valid = 1; mem_read = 1; regwrite = 1; rd = 5'd4; alu_data = 64'h40;
    branch = 1; zero = 1; pc_branch = 32'h1234_5678;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || pc_src !== 1'b1) begin errors++; $display("FAIL timeout_c0: stall=%b pc_src=%b want 1/1", stall, pc_src); end
    checks++; if (pc_branch_out !== 32'h1234_5678) begin errors++; $display("FAIL branch_target: got %h want 12345678", pc_branch_out); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      exp_stall = (i < 5);
      checks++; if (dmem_req !== 1'b1 || stall !== exp_stall || bus_err !== 1'b0) begin errors++; $display("FAIL timeout_c%0d: req=%b stall=%b bus=%b want 1/%b/0", i, dmem_req, stall, bus_err, exp_stall); end
      checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL branch_during_stall_c%0d: got %b want 1", i, pc_src); end
    end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0) begin errors++; $display("FAIL timeout_err: bus=%b valid=%b rw=%b want 1/1/0", bus_err, wb_valid, wb_regwrite); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got %b want 0", dmem_req); end
    tick(); in_valid = 1; regwrite = 1; rd = 5'd11; alu_data = 64'h77; branch = 1; zero = 0;
    @(negedge clk);
    checks++; if (bus_err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL timeout_idle: bus=%b stall=%b want 0/0", bus_err, stall); end
    checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %b want 0", pc_src); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_alu_data !== 64'h77) begin errors++; $display("FAIL timeout_recover: valid=%b rd=%0d data=%h want 1/11/77", wb_valid, wb_rd, wb_alu_data); end
    $display("timeout: bus_err after 5 access cycles, branch passthrough checked");
  endtask

  task automatic test_back_to_back();
    tick(); clear_in(); in_valid = 1; mem_read = 1; mem_to_reg = 1; regwrite = 1; rd = 5'd1; alu_data = 64'h100;
    @(negedge clk);
    tick(); dmem_ack = 1; dmem_rdata = 64'h1111;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_first: req=%b stall=%b want 1/0", dmem_req, stall); end
    tick(); clear_in(); in_valid = 1; mem_read = 1; mem_to_reg = 1; regwrite = 1; rd = 5'd2; alu_data = 64'h108;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_gap: req=%b stall=%b want 0/1", dmem_req, stall); end
    checks++; if (wb_valid !== 1'b1 || wb_mem_data !== 64'h1111 || wb_rd !== 5'd1) begin errors++; $display("FAIL b2b_wb1: valid=%b data=%h rd=%0d want 1/1111/1", wb_valid, wb_mem_data, wb_rd); end
    tick(); dmem_ack = 1; dmem_rdata = 64'h2222;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h108 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_second: req=%b addr=%h valid=%b want 1/108/0", dmem_req, dmem_addr, wb_valid); end
    tick(); clear_in();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_mem_data !== 64'h2222 || wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_wb2: valid=%b data=%h rd=%0d want 1/2222/2", wb_valid, wb_mem_data, wb_rd); end
    $display("back_to_back: loads at 0x100 and 0x108 checked");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_misalign();
    test_timeout_branch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
